// File: rtl/ws2812_rx_if.sv
// Signal bundle between a WS2812 line source and the ws2812_rx decoder.
// The master side drives the raw line; the slave side returns decoded words and pulses.
interface ws2812_rx_if;
   logic        din;
   logic [23:0] rgb_data;
   logic        valid;
   logic        frame_end;
   logic [15:0] word_count;
   logic        error;

   modport master (
      output din,
      input  rgb_data,
      input  valid,
      input  frame_end,
      input  word_count,
      input  error
   );

   modport slave (
      input  din,
      output rgb_data,
      output valid,
      output frame_end,
      output word_count,
      output error
   );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 single-wire decoder: classifies pulse high times into bits, rebuilds 24-bit
// MSB-first words and reports frame ends after a long low period.
module ws2812_rx #(
   parameter int unsigned CLK_FREQ      = 27000000,
   parameter int unsigned T_THRESH_NS   = 600,
   parameter int unsigned T_MIN_HIGH_NS = 100,
   parameter int unsigned T_MAX_HIGH_NS = 5000,
   parameter int unsigned T_RESET_US    = 50
) (
   input  logic       clk,
   input  logic       rst,
   ws2812_rx_if.slave bus
);

   localparam longint unsigned ThreshCyc64 =
      (64'(CLK_FREQ) * 64'(T_THRESH_NS)) / 64'd1000000000;
   localparam longint unsigned MinCyc64 =
      (64'(CLK_FREQ) * 64'(T_MIN_HIGH_NS)) / 64'd1000000000;
   localparam longint unsigned MaxCyc64 =
      (64'(CLK_FREQ) * 64'(T_MAX_HIGH_NS)) / 64'd1000000000;
   localparam longint unsigned ResetCyc64 =
      (64'(CLK_FREQ) * 64'(T_RESET_US)) / 64'd1000000;

   localparam logic [16:0] ThreshCyc = 17'(ThreshCyc64);
   localparam logic [16:0] MinCyc    = 17'(MinCyc64);
   localparam logic [16:0] MaxCyc    = 17'(MaxCyc64);
   localparam logic [16:0] ResetCyc  = 17'(ResetCyc64);

   typedef enum logic [1:0] {
      StSyncWait,
      StIdle,
      StHigh,
      StLow
   } state_e;

   logic        din_meta_q, din_s_q, din_p_q;
   logic        rise, fall;
   logic [16:0] run_len;
   logic        bit_val;
   logic [23:0] shifted;

   state_e      state_q, state_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [23:0] shift_q, shift_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [23:0] rgb_data_q, rgb_data_d;
   logic        valid_q, valid_d;
   logic        frame_end_q, frame_end_d;
   logic [15:0] word_count_q, word_count_d;
   logic        error_q, error_d;

   assign rise = din_s_q & ~din_p_q;
   assign fall = ~din_s_q & din_p_q;

   // tcnt clears on the edge cycle, so tcnt+1 is the length of the level that just ended
   // (on an edge) or the number of completed cycles of the current level (otherwise).
   assign run_len = {1'b0, tcnt_q} + 17'd1;
   assign bit_val = (run_len >= ThreshCyc);
   assign shifted = {shift_q[22:0], bit_val};

   always_comb begin
      state_d      = state_q;
      tcnt_d       = (rise | fall) ? 16'd0 :
                     (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      rgb_data_d   = rgb_data_q;
      valid_d      = 1'b0;
      frame_end_d  = 1'b0;
      error_d      = 1'b0;
      // word_count is visible through the frame_end cycle, then drops to zero.
      word_count_d = frame_end_q ? 16'd0 : word_count_q;

      unique case (state_q)
         StSyncWait: begin
            bit_cnt_d = 5'd0;
            if (!din_s_q && !fall && (run_len >= ResetCyc)) begin
               state_d      = StIdle;
               word_count_d = 16'd0;
            end
         end

         StIdle: begin
            if (rise) begin
               state_d = StHigh;
            end
         end

         StHigh: begin
            if (fall) begin
               if (run_len < MinCyc) begin
                  error_d   = 1'b1;
                  bit_cnt_d = 5'd0;
                  state_d   = StSyncWait;
               end else begin
                  shift_d = shifted;
                  state_d = StLow;
                  if (bit_cnt_q == 5'd23) begin
                     rgb_data_d   = shifted;
                     valid_d      = 1'b1;
                     bit_cnt_d    = 5'd0;
                     word_count_d = (word_count_q == 16'hFFFF) ? word_count_q
                                                               : word_count_q + 16'd1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end else if (run_len >= MaxCyc) begin
               error_d   = 1'b1;
               bit_cnt_d = 5'd0;
               state_d   = StSyncWait;
            end
         end

         StLow: begin
            if (rise) begin
               state_d = StHigh;
            end else if (!din_s_q && (run_len >= ResetCyc)) begin
               frame_end_d = 1'b1;
               error_d     = (bit_cnt_q != 5'd0);
               bit_cnt_d   = 5'd0;
               state_d     = StIdle;
            end
         end

         default: begin
            state_d = StSyncWait;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         din_meta_q   <= 1'b0;
         din_s_q      <= 1'b0;
         din_p_q      <= 1'b0;
         state_q      <= StSyncWait;
         tcnt_q       <= 16'd0;
         shift_q      <= 24'd0;
         bit_cnt_q    <= 5'd0;
         rgb_data_q   <= 24'd0;
         valid_q      <= 1'b0;
         frame_end_q  <= 1'b0;
         word_count_q <= 16'd0;
         error_q      <= 1'b0;
      end else begin
         din_meta_q   <= bus.din;
         din_s_q      <= din_meta_q;
         din_p_q      <= din_s_q;
         state_q      <= state_d;
         tcnt_q       <= tcnt_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         rgb_data_q   <= rgb_data_d;
         valid_q      <= valid_d;
         frame_end_q  <= frame_end_d;
         word_count_q <= word_count_d;
         error_q      <= error_d;
      end
   end

   assign bus.rgb_data   = rgb_data_q;
   assign bus.valid      = valid_q;
   assign bus.frame_end  = frame_end_q;
   assign bus.word_count = word_count_q;
   assign bus.error      = error_q;

endmodule
